// File: rtl/present_dec_core_if.sv
// present_dec_core_if: ciphertext/key input and plaintext output handshakes of the PRESENT-80 decryption core.
interface present_dec_core_if;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:63] ciphertext, plaintext;
    logic [0:79] key;
    modport master(output in_valid, ciphertext, key, out_ready, input in_ready, out_valid, plaintext, busy);
    modport slave(input in_valid, ciphertext, key, out_ready, output in_ready, out_valid, plaintext, busy);
endinterface

// File: rtl/present_dec_core.sv
// present_dec_core: iterative PRESENT-80 decryption, one inverse round per clock.
// Buses are MSB-first ([0] is the MSB); the final round key K32 is cached per master key.
module present_dec_core #(
    parameter bit KEY_CACHE = 1'b1
) (
    input logic clk,
    input logic rst,
    present_dec_core_if.slave io
);
    typedef enum logic [2:0] {IDLE, KEYGEN, DEC, FIN, DONE} state_t;
    localparam logic [0:63] SB  = 64'hC56B90AD3EF84712;
    localparam logic [0:63] ISB = 64'h5EF8C12DB463079A;

    state_t      state, state_n;
    logic [0:63] s, s_n, pt, pt_n;
    logic [0:79] k, k_n, k32, k32_n, tag, tag_n;
    logic [4:0]  rc, rc_n;
    logic        ov, ov_n, cv, cv_n, hit;

    function automatic logic [0:3] sbox(input logic [0:3] x);
        return SB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [0:3] isbox(input logic [0:3] x);
        return ISB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [0:63] inv_round(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
        y[63] = x[63];
        for (int n = 0; n < 16; n++) y[4*n +: 4] = isbox(y[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [0:79] fwd_key(input logic [0:79] x, input logic [4:0] r);
        return {sbox(x[61:64]), x[65:79], x[0:40], x[41:45] ^ r, x[46:60]};
    endfunction

    // Undo fwd_key: strip the counter, invert the S-box, then rotate back by 19.
    function automatic logic [0:79] inv_key(input logic [0:79] x, input logic [4:0] r);
        logic [0:79] t;
        t = x;
        t[60:64] = t[60:64] ^ r;
        t[0:3] = isbox(t[0:3]);
        return {t[19:79], t[0:18]};
    endfunction

    assign hit          = KEY_CACHE && cv && (io.key == tag);
    assign io.in_ready  = (state == IDLE);
    assign io.busy      = (state == KEYGEN) || (state == DEC) || (state == FIN);
    assign io.out_valid = ov;
    assign io.plaintext = pt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            k32   <= '0;
            tag   <= '0;
            rc    <= '0;
            pt    <= '0;
            ov    <= 1'b0;
            cv    <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            k     <= k_n;
            k32   <= k32_n;
            tag   <= tag_n;
            rc    <= rc_n;
            pt    <= pt_n;
            ov    <= ov_n;
            cv    <= cv_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        k_n     = k;
        k32_n   = k32;
        tag_n   = tag;
        rc_n    = rc;
        pt_n    = pt;
        ov_n    = ov;
        cv_n    = cv;
        case (state)
            IDLE: if (io.in_valid) begin
                s_n     = io.ciphertext;
                tag_n   = io.key;
                k_n     = hit ? k32 : io.key;
                rc_n    = hit ? 5'd31 : 5'd1;
                cv_n    = hit;
                state_n = hit ? DEC : KEYGEN;
            end
            KEYGEN: begin
                k_n     = fwd_key(k, rc);
                rc_n    = (rc == 5'd31) ? rc : rc + 5'd1;
                k32_n   = (rc == 5'd31) ? k_n : k32;
                cv_n    = cv || (rc == 5'd31);
                state_n = (rc == 5'd31) ? DEC : KEYGEN;
            end
            DEC: begin
                s_n     = inv_round(s ^ k[0:63]);
                k_n     = inv_key(k, rc);
                rc_n    = (rc == 5'd1) ? rc : rc - 5'd1;
                state_n = (rc == 5'd1) ? FIN : DEC;
            end
            FIN: begin
                pt_n    = s ^ k[0:63];
                ov_n    = 1'b1;
                state_n = DONE;
            end
            DONE: if (io.out_ready) begin
                ov_n    = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
